// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, key map and idle constants for the keypad scanner
// (optional multi-key rejection is enabled in keypad_scan_ctrl by KEYPAD_MULTI_KEY_REJECT_EN)
package keypad_pkg;

   typedef enum logic {SCAN, HOLD} scan_state_t;

   localparam logic [3:0] ROW_INIT = 4'b1110;
   localparam logic [3:0] COL_IDLE = 4'b1111;

   // KEYMAP[row][col]; row 3 carries the '*'(E) and '#'(F) keys
   localparam logic [3:0] KEYMAP [0:3][0:3] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   // index of the lowest active-low column; caller guarantees at least one is low
   function automatic logic [1:0] low_col_idx(input logic [3:0] c);
      return !c[0] ? 2'd0 : !c[1] ? 2'd1 : !c[2] ? 2'd2 : 2'd3;
   endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// keypad_col_sync: multi-stage synchronizer for the asynchronous active-low column pins
module keypad_col_sync
   import keypad_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] i_col,
   output logic [3:0] o_col
);

   logic [3:0] r_sync [SYNC_STAGES];

   // shift the raw columns through the chain; reset to the idle (released) pattern
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= COL_IDLE;
      end else begin
         r_sync[0] <= i_col;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   assign o_col = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad row-scan sequencer feeding keypad_debouncer
// Optional: `define KEYPAD_MULTI_KEY_REJECT_EN treats multi-column hits as no key and sets ghost_seen.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int ROW_CYCLES  = 3000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] col_pin,
   input  logic       scan_stop,
   output logic [3:0] row,
   output logic       key_detected,
   output logic [3:0] key_code,
   output logic [3:0] col
);

   localparam int DW = $clog2(ROW_CYCLES);
   localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_CYCLES - 1);

   scan_state_t r_state, w_state_n;
   logic [1:0]    r_row_idx, w_row_idx_n;
   logic [DW-1:0] r_dwell, w_dwell_n;
   logic          r_kd, w_kd_n;
   logic [3:0]    r_code, w_code_n;
   logic [3:0]    r_col, w_col_n;
   logic [3:0]    w_col_s;
   logic [7:0]    w_row_rot;
   logic          w_sample;
   logic          w_accept;

   keypad_col_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_col (col_pin),
      .o_col (w_col_s)
   );

   assign w_sample = (r_state == SCAN) && (r_dwell == DWELL_LAST);

`ifdef KEYPAD_MULTI_KEY_REJECT_EN
   logic w_multi;
   logic ghost_seen;
   // more than one low column: clearing the lowest zero leaves another zero
   assign w_multi  = |((~w_col_s) & ((~w_col_s) - 4'd1));
   assign w_accept = (w_col_s != COL_IDLE) && !w_multi;
   // sticky record that a ghosting sample was rejected
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ghost_seen <= 1'b0;
      else if (w_sample && w_multi) ghost_seen <= 1'b1;
   end
`else
   assign w_accept = (w_col_s != COL_IDLE);
`endif

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= SCAN;
         r_row_idx <= 2'd0;
         r_dwell   <= '0;
         r_kd      <= 1'b0;
         r_code    <= 4'h0;
         r_col     <= COL_IDLE;
      end else begin
         r_state   <= w_state_n;
         r_row_idx <= w_row_idx_n;
         r_dwell   <= w_dwell_n;
         r_kd      <= w_kd_n;
         r_code    <= w_code_n;
         r_col     <= w_col_n;
      end
   end

   // scan dwell/advance, key capture on hit, hold until released and debouncer lets go
   always_comb begin
      w_state_n   = r_state;
      w_row_idx_n = r_row_idx;
      w_dwell_n   = r_dwell;
      w_kd_n      = r_kd;
      w_code_n    = r_code;
      w_col_n     = r_col;
      if (r_state == SCAN) begin
         w_dwell_n = w_sample ? '0 : r_dwell + DW'(1);
         if (w_sample && w_accept) begin
            w_state_n = HOLD;
            w_col_n   = w_col_s;
            w_code_n  = KEYMAP[r_row_idx][low_col_idx(w_col_s)];
            w_kd_n    = 1'b1;
         end else if (w_sample) begin
            w_row_idx_n = r_row_idx + 2'd1;
         end
      end else begin
         w_dwell_n = '0;
         w_kd_n    = |(~w_col_s & ~r_col);
         if (w_col_s == COL_IDLE && !scan_stop) begin
            w_state_n   = SCAN;
            w_col_n     = COL_IDLE;
            w_kd_n      = 1'b0;
            w_row_idx_n = r_row_idx + 2'd1;
         end
      end
   end

   // rotate the single low bit of ROW_INIT left by the row index
   assign w_row_rot    = {ROW_INIT, ROW_INIT} << r_row_idx;
   assign row          = w_row_rot[7:4];
   assign key_detected = r_kd;
   assign key_code     = r_code;
   assign col          = r_col;

endmodule
